dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 43 ++++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the pipeline MEM stage (master) and the data-memory responder (slave).
// DMEM_ALIGN_CHECK_EN adds the align_err response flag.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output align_err,
`endif
    output stall
  );

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    input  align_err,
`endif
    input  stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed access latency, stall output.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests respond with align_err and do not write.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LoadCnt = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    mis_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [31:0]             mem_q [Depth];

  logic                    accept, commit;
  logic                    req_mis;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    cmt_we, cmt_mis;
  logic [DEPTH_LOG2-1:0]   cmt_idx;
  logic [31:0]             cmt_wdata;
  logic                    unused_addr;

  assign req_idx     = bus.req_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = (bus.req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = (LATENCY > 0) ? StWait : StResp;
          cnt_d   = LoadCnt;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The edge entering RESP commits the access; with zero latency that is the accept
  // edge itself, so the request inputs are used directly instead of the latched copy.
  assign commit    = (state_d == StResp) && (state_q != StResp);
  assign cmt_we    = (state_q == StIdle) ? bus.req_we    : we_q;
  assign cmt_idx   = (state_q == StIdle) ? req_idx       : idx_q;
  assign cmt_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
  assign cmt_mis   = (state_q == StIdle) ? req_mis       : mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        idx_q   <= req_idx;
        wdata_q <= bus.req_wdata;
        mis_q   <= req_mis;
      end
      if (commit) begin
        err_q <= cmt_mis;
        if (cmt_mis) begin
          rdata_q <= 32'd0;
        end else if (cmt_we) begin
          rdata_q <= cmt_wdata;
        end else begin
          rdata_q <= mem_q[cmt_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (commit && cmt_we && !cmt_mis) begin
      mem_q[cmt_idx] <= cmt_wdata;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.stall      = ((state_q == StIdle) && bus.req_valid) || (state_q == StWait);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.align_err  = (state_q == StResp) && err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: cycle-level behavioural model plus directed accesses.
module tb_dmem_responder;
  localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_LOG2(8),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age counts cycles since the accept edge (-1 = idle).
  int          age = -1;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;
  logic [31:0] mmem [256];

  task automatic model_commit();
    int idx;
    idx   = int'((m_addr >> 2) % 256);
    m_err = AlignEn && (m_addr % 4 != 0);
    if (m_err) m_rdata = 32'd0;
    else if (m_we) begin
      mmem[idx] = m_wdata;
      m_rdata   = m_wdata;
    end else m_rdata = mmem[idx];
  endtask

  initial begin
    foreach (mmem[i]) mmem[i] = 32'd0;
    m_rdata = 32'd0;
    m_err   = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmp_ready", 32'(bus.req_ready), 32'(age < 0));
      chk("cmp_stall", 32'(bus.stall), 32'((age < 0 && bus.req_valid) || (age >= 1 && age <= LAT)));
      chk("cmp_valid", 32'(bus.resp_valid), 32'(age == LAT + 1));
      chk("cmp_rdata", bus.resp_rdata, m_rdata);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("cmp_align", 32'(bus.align_err), 32'(age == LAT + 1 && m_err));
`endif
      if (rst) begin
        age = -1;
        foreach (mmem[i]) mmem[i] = 32'd0;
        m_rdata = 32'd0;
        m_err   = 1'b0;
      end else if (age < 0) begin
        if (bus.req_valid) begin
          m_we = bus.req_we; m_addr = bus.req_addr; m_wdata = bus.req_wdata;
          age = 1;
          if (LAT == 0) model_commit();
        end
      end else if (age == LAT + 1) begin
        age = -1;
      end else begin
        age++;
        if (age == LAT + 1) model_commit();
      end
    end
  end

  // One access starting in an idle cycle; returns in the RESP cycle (+1ns).
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input bit hold,
                        input bit exp_err);
    int n;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    #1;
    chk({name, "_stall_t"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    n = 1;
    if (hold) begin
      bus.req_we = 1'b1; bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFF_FFFF;
    end else bus.req_valid = 1'b0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    chk({name, "_lat"}, 32'(n), 32'(LAT + 1));
    chk({name, "_rdata"}, bus.resp_rdata, exp);
`ifdef DMEM_ALIGN_CHECK_EN
    chk({name, "_aerr"}, 32'(bus.align_err), 32'(exp_err));
`else
    if (exp_err) chk({name, "_aerr_unsupported"}, 32'd1, 32'd0);
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_rdata", bus.resp_rdata, 32'd0);

    access("load_cold", 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    access("store_40", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ready_t4", 32'(bus.req_ready), 32'd1);
    access("load_40", 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access("store_400", 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    access("load_wrap0", 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    access("store_44", 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0);
    access("load_hold", 1'b0, 32'hFFFF_F444, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0);
    access("load_0_kept", 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    if (AlignEn) begin
      access("store_mis", 1'b1, 32'h0000_0042, 32'h5555_5555, 32'h0, 1'b0, 1'b1);
      access("load_after_mis", 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    end else begin
      access("load_lowbits", 1'b0, 32'h0000_0043, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    end

    // Reset while a store sits in WAIT.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1;
    bus.req_addr = 32'h0000_0080; bus.req_wdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("wait_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    access("load_80", 1'b0, 32'h0000_0080, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    access("load_40_clr", 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
